fetch: RTL and testbench

- Instruction-fetch stage of the in-order pipeline, directly upstream of the instruction decoder.
- Owns the PC and drives the instruction bus request/response handshake.
- Presents {valid, pc, raw instruction} to decode through a valid/ready output register, with a one-entry skid buffer.
- Accepts redirects from execute and discards in-flight responses when a redirect makes them stale.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_skid.sv | 28 ++
 rtl/fetch.sv | 130 +++++++++++++
 tb/tb_fetch.sv | 130 +++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int          FETCH_PC_W     = 64;
  localparam logic [63:0] FETCH_PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic                  valid;
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
    logic                  exc;
  } fetch_data_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DROP  = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction bus, redirect and decode-side signals of the fetch stage
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int PC_W = FETCH_PC_W
);
  logic            ireq_valid;
  logic [PC_W-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            f_valid;
  logic [PC_W-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            f_exc;
  logic            d_ready;

  modport master (
    output ireq_valid, ireq_addr, f_valid, f_pc, f_instr, f_exc,
    input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, d_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, f_valid, f_pc, f_instr, f_exc,
    output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, d_ready
  );
endinterface

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry holding buffer for a word fetched while decode stalls
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_data_t load_data,
  output logic        full,
  output fetch_data_t data
);

  // clear wins over load so a redirect in the same cycle never leaves a stale entry
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction-fetch stage: PC, bus handshake, output register and redirects
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter logic [PC_W-1:0] PC_RESET = PC_W'(FETCH_PC_RESET)
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  fetch_data_t     out_q;
  fetch_data_t     skid_data;
  fetch_data_t     fetched;
  logic            skid_full;
  logic            skid_load;
  logic            skid_unload;
  logic            can_load;
  logic            misaligned;

`ifdef FETCH_MISALIGN_EN
  assign misaligned = (state == S_FETCH) && (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign can_load = !out_q.valid || bus.d_ready;
  assign fetched  = '{valid: 1'b1, pc: FETCH_PC_W'(pc), instr: bus.iresp_data, exc: 1'b0};

  assign bus.ireq_valid = (((state == S_FETCH) && !misaligned) || (state == S_DROP)) && !reset;
  assign bus.ireq_addr  = pc;
  assign bus.f_valid    = out_q.valid;
  assign bus.f_pc       = PC_W'(out_q.pc);
  assign bus.f_instr    = out_q.instr;
  assign bus.f_exc      = out_q.exc;

  assign skid_load   = (state == S_FETCH) && !misaligned && bus.iresp_data_ok &&
                       !can_load && !bus.redirect_valid;
  assign skid_unload = (state == S_FULL) && bus.d_ready && !bus.redirect_valid;

  fetch_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (bus.redirect_valid),
    .load_data (fetched),
    .full      (skid_full),
    .data      (skid_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= PC_RESET;
      target <= '0;
      out_q  <= '0;
    end else if (bus.redirect_valid) begin
      // redirect squashes the output and overrides any decode handshake this cycle
      out_q.valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.iresp_data_ok || misaligned) begin
            pc <= bus.redirect_pc;
          end else begin
            target <= bus.redirect_pc;
            state  <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.iresp_data_ok) begin
            pc    <= bus.redirect_pc;
            state <= S_FETCH;
          end else begin
            target <= bus.redirect_pc;
          end
        end
        default: begin
          pc    <= bus.redirect_pc;
          state <= S_FETCH;
        end
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (misaligned) begin
            if (can_load) begin
              out_q <= '{valid: 1'b1, pc: FETCH_PC_W'(pc), instr: NOP_INSTR, exc: 1'b1};
              state <= S_TRAP;
            end
          end else if (bus.iresp_data_ok) begin
            pc <= pc + PC_W'(4);
            if (can_load) begin
              out_q <= fetched;
            end else begin
              state <= S_FULL;
            end
          end else if (bus.d_ready) begin
            out_q.valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (bus.d_ready && skid_full) begin
            out_q <= skid_data;
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          // stale response: throw the word away and restart at the latched target
          if (bus.iresp_data_ok) begin
            pc    <= target;
            state <= S_FETCH;
          end
        end
        S_TRAP: begin
          if (bus.d_ready) begin
            out_q.valid <= 1'b0;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for the fetch stage
module tb_fetch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_if #(.PC_W(64)) bus_if ();

  fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] d_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one cycle's inputs just after the falling edge, then let them settle
  task automatic cyc(input logic dok, input logic [63:0] daddr, input logic rv,
                     input logic [63:0] rpc, input logic dr);
    @(negedge clk);
    reset                 = 1'b0;
    bus_if.iresp_data_ok  = dok;
    bus_if.iresp_data     = dok ? d_of(daddr) : 32'hDEAD_BEEF;
    bus_if.redirect_valid = rv;
    bus_if.redirect_pc    = rpc;
    bus_if.d_ready        = dr;
    #1;
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
    check({tag, ".ireq_valid"}, 64'(bus_if.ireq_valid), 64'(v));
    if (v) check({tag, ".ireq_addr"}, bus_if.ireq_addr, a);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] p,
                         input logic [31:0] ins, input logic e);
    check({tag, ".f_valid"}, 64'(bus_if.f_valid), 64'(v));
    if (v) begin
      check({tag, ".f_pc"}, bus_if.f_pc, p);
      check({tag, ".f_instr"}, 64'(bus_if.f_instr), 64'(ins));
      check({tag, ".f_exc"}, 64'(bus_if.f_exc), 64'(e));
    end
  endtask

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  initial begin
    bus_if.iresp_data_ok  = 1'b0;
    bus_if.iresp_data     = '0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.d_ready        = 1'b0;

    @(negedge clk); #1;
    check("rst.ireq_valid", 64'(bus_if.ireq_valid), 64'd0);
    check("rst.f_valid", 64'(bus_if.f_valid), 64'd0);
    check("rst.f_pc", bus_if.f_pc, 64'd0);
    check("rst.f_instr", 64'(bus_if.f_instr), 64'd0);
    check("rst.f_exc", 64'(bus_if.f_exc), 64'd0);

    // streaming at one instruction per cycle
    cyc(1, B + 0, 0, 0, 1);  chk_req("s1", 1, B + 0); chk_out("s1", 0, 0, 0, 0);
    cyc(1, B + 4, 0, 0, 1);  chk_req("s2", 1, B + 4); chk_out("s2", 1, B + 0, d_of(B + 0), 0);
    cyc(1, B + 8, 0, 0, 1);  chk_req("s3", 1, B + 8); chk_out("s3", 1, B + 4, d_of(B + 4), 0);

    // decode stall: output holds +8, +C goes to the skid
    cyc(1, B + 12, 0, 0, 0); chk_req("k1", 1, B + 12); chk_out("k1", 1, B + 8, d_of(B + 8), 0);
    cyc(0, 0, 0, 0, 0);      chk_req("k2", 0, 0);      chk_out("k2", 1, B + 8, d_of(B + 8), 0);
    cyc(0, 0, 0, 0, 0);      chk_req("k3", 0, 0);      chk_out("k3", 1, B + 8, d_of(B + 8), 0);
    cyc(0, 0, 0, 0, 1);      chk_req("k4", 0, 0);      chk_out("k4", 1, B + 8, d_of(B + 8), 0);
    cyc(0, 0, 0, 0, 1);      chk_req("k5", 1, B + 16); chk_out("k5", 1, B + 12, d_of(B + 12), 0);

    // redirect while the +0x10 request is outstanding; stale reply three cycles later
    cyc(0, 0, 1, B + 64'h1000, 1); chk_req("r1", 1, B + 16); chk_out("r1", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);            chk_req("r2", 1, B + 16); chk_out("r2", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);            chk_req("r3", 1, B + 16);
    cyc(1, B + 16, 0, 0, 1);       chk_req("r4", 1, B + 16); chk_out("r4", 0, 0, 0, 0);
    cyc(1, B + 64'h1000, 0, 0, 1); chk_req("r5", 1, B + 64'h1000); chk_out("r5", 0, 0, 0, 0);

    // redirect coinciding with data_ok drops the word
    cyc(1, B + 64'h1004, 1, B + 64'h2000, 1);
    chk_out("rd", 1, B + 64'h1000, d_of(B + 64'h1000), 0);
    // two redirects while dropping: latest target wins
    cyc(0, 0, 1, 64'h100, 1); chk_req("dd1", 1, B + 64'h2000); chk_out("dd1", 0, 0, 0, 0);
    cyc(0, 0, 1, 64'h200, 1); chk_req("dd2", 1, B + 64'h2000); chk_out("dd2", 0, 0, 0, 0);
    cyc(1, B + 64'h2000, 0, 0, 1); chk_req("dd3", 1, B + 64'h2000);
    cyc(1, 64'h200, 0, 0, 1); chk_req("dd4", 1, 64'h200); chk_out("dd4", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);       chk_req("dd5", 1, 64'h204); chk_out("dd5", 1, 64'h200, d_of(64'h200), 0);

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    cyc(1, 64'h204, 0, 0, 1);
    cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1); chk_req("w1", 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0, 0, 1); chk_req("w2", 1, 64'h0);
    chk_out("w2", 1, 64'hFFFF_FFFF_FFFF_FFFC, d_of(64'hFFFF_FFFF_FFFF_FFFC), 0);

    // redirect to a misaligned target
    cyc(0, 0, 1, B + 2, 1);
    cyc(1, 64'h0, 0, 0, 1);
`ifdef FETCH_MISALIGN_EN
    cyc(0, 0, 0, 0, 1);      chk_req("m1", 0, 0); chk_out("m1", 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);      chk_req("m2", 0, 0); chk_out("m2", 1, B + 2, 32'h0000_0013, 1);
    cyc(0, 0, 0, 0, 1);      chk_req("m3", 0, 0); chk_out("m3", 1, B + 2, 32'h0000_0013, 1);
    cyc(0, 0, 1, B + 4, 1);  chk_req("m4", 0, 0); chk_out("m4", 0, 0, 0, 0);
    cyc(1, B + 4, 0, 0, 1);  chk_req("m5", 1, B + 4);
    cyc(0, 0, 0, 0, 0);      chk_out("m6", 1, B + 4, d_of(B + 4), 0);
`else
    cyc(1, B + 2, 0, 0, 1);  chk_req("m1", 1, B + 2);
    cyc(0, 0, 0, 0, 1);      chk_req("m2", 1, B + 6); chk_out("m2", 1, B + 2, d_of(B + 2), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
